// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of a single-port data memory: grants one request per cycle,
// screens out illegal accesses and returns a registered response one cycle later.
module dmem_arbiter #(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter bit          FIXED_PRIO  = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        a_valid,
    output logic        a_ready,
    input  logic        a_we,
    input  logic [2:0]  a_size,
    input  logic [31:0] a_addr,
    input  logic [31:0] a_wdata,
    output logic        a_rvalid,
    output logic [31:0] a_rdata,
    output logic        a_err,
    input  logic        b_valid,
    output logic        b_ready,
    input  logic        b_we,
    input  logic [2:0]  b_size,
    input  logic [31:0] b_addr,
    input  logic [31:0] b_wdata,
    output logic        b_rvalid,
    output logic [31:0] b_rdata,
    output logic        b_err,
    output logic [15:0] conflict_cnt,
    output logic [2:0]  mem_readcontrol,
    output logic [2:0]  mem_writecontrol,
    output logic [31:0] mem_address,
    output logic [31:0] mem_writedata,
    input  logic [31:0] mem_read_data
);
    localparam logic [31:0] ADDR_LIMIT = 32'(DEPTH_WORDS * 4);
    localparam logic [2:0]  CTRL_NONE  = 3'b111;

    typedef enum logic {GRANT_A = 1'b0, GRANT_B = 1'b1} grant_e;

    grant_e      last_grant_q, last_grant_d;
    logic        a_rvalid_q, a_rvalid_d, b_rvalid_q, b_rvalid_d;
    logic        a_err_q, a_err_d, b_err_q, b_err_d;
    logic [31:0] a_rdata_q, a_rdata_d, b_rdata_q, b_rdata_d;
    logic [15:0] conflict_cnt_q, conflict_cnt_d;

    logic        grant_a, grant_b, sel_valid, sel_we, req_err;
    logic [2:0]  sel_size;
    logic [31:0] sel_addr, sel_wdata, load_data;

    always_comb begin
        grant_a = a_valid;
        grant_b = b_valid;
        if (a_valid && b_valid) begin
            grant_a = FIXED_PRIO || (last_grant_q == GRANT_B);
            grant_b = !grant_a;
        end
    end

    assign a_ready   = grant_a;
    assign b_ready   = grant_b;
    assign sel_valid = grant_a || grant_b;
    assign sel_we    = grant_b ? b_we    : a_we;
    assign sel_size  = grant_b ? b_size  : a_size;
    assign sel_addr  = grant_b ? b_addr  : a_addr;
    assign sel_wdata = grant_b ? b_wdata : a_wdata;

    always_comb begin
        req_err = 1'b0;
        if (sel_addr >= ADDR_LIMIT) req_err = 1'b1;
        case (sel_size)
            3'b001, 3'b101:         if (sel_addr[0]) req_err = 1'b1;
            3'b010:                 if (sel_addr[1:0] != 2'b00) req_err = 1'b1;
            3'b011, 3'b110, 3'b111: req_err = 1'b1;
            default: ;
        endcase
        // Unsigned sizes only make sense for loads
        if (sel_we && sel_size[2]) req_err = 1'b1;
    end

    always_comb begin
        mem_readcontrol  = CTRL_NONE;
        mem_writecontrol = CTRL_NONE;
        mem_address      = 32'h0;
        mem_writedata    = 32'h0;
        if (sel_valid) begin
            mem_address   = sel_addr;
            mem_writedata = sel_wdata;
            // Reset gating keeps a request presented during reset from touching memory
            if (!req_err && rst_n) begin
                if (sel_we) mem_writecontrol = sel_size;
                else        mem_readcontrol  = sel_size;
            end
        end
    end

    assign load_data = (!sel_we && !req_err) ? mem_read_data : 32'h0;

    always_comb begin
        a_rvalid_d     = grant_a;
        b_rvalid_d     = grant_b;
        a_err_d        = grant_a ? req_err   : a_err_q;
        b_err_d        = grant_b ? req_err   : b_err_q;
        a_rdata_d      = grant_a ? load_data : a_rdata_q;
        b_rdata_d      = grant_b ? load_data : b_rdata_q;
        last_grant_d   = last_grant_q;
        if (grant_a) last_grant_d = GRANT_A;
        if (grant_b) last_grant_d = GRANT_B;
        conflict_cnt_d = conflict_cnt_q;
        if (a_valid && b_valid && conflict_cnt_q != 16'hFFFF)
            conflict_cnt_d = conflict_cnt_q + 16'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_q   <= GRANT_B;
            a_rvalid_q     <= 1'b0;
            b_rvalid_q     <= 1'b0;
            a_err_q        <= 1'b0;
            b_err_q        <= 1'b0;
            a_rdata_q      <= 32'h0;
            b_rdata_q      <= 32'h0;
            conflict_cnt_q <= 16'h0;
        end else begin
            last_grant_q   <= last_grant_d;
            a_rvalid_q     <= a_rvalid_d;
            b_rvalid_q     <= b_rvalid_d;
            a_err_q        <= a_err_d;
            b_err_q        <= b_err_d;
            a_rdata_q      <= a_rdata_d;
            b_rdata_q      <= b_rdata_d;
            conflict_cnt_q <= conflict_cnt_d;
        end
    end

    assign a_rvalid     = a_rvalid_q;
    assign b_rvalid     = b_rvalid_q;
    assign a_err        = a_err_q;
    assign b_err        = b_err_q;
    assign a_rdata      = a_rdata_q;
    assign b_rdata      = b_rdata_q;
    assign conflict_cnt = conflict_cnt_q;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: byte-addressed memory model on the memory port, a word-level
// reference model checked every cycle, and directed scenarios with literal expectations.
module tb_dmem_arbiter;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        a_valid, a_we, b_valid, b_we;
    logic [2:0]  a_size, b_size;
    logic [31:0] a_addr, a_wdata, b_addr, b_wdata;
    logic        a_ready, b_ready, a_rvalid, b_rvalid, a_err, b_err;
    logic [31:0] a_rdata, b_rdata;
    logic [15:0] conflict_cnt;
    logic [2:0]  mem_readcontrol, mem_writecontrol;
    logic [31:0] mem_address, mem_writedata, mem_read_data;

    logic        f_a_ready, f_b_ready, f_a_rvalid, f_b_rvalid, f_a_err, f_b_err;
    logic [31:0] f_a_rdata, f_b_rdata, f_mem_address, f_mem_writedata;
    logic [15:0] f_conflict_cnt;
    logic [2:0]  f_mem_readcontrol, f_mem_writecontrol;

    int n_vec = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(.DEPTH_WORDS(256), .FIXED_PRIO(1'b0)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_valid(a_valid), .a_ready(a_ready), .a_we(a_we), .a_size(a_size), .a_addr(a_addr),
        .a_wdata(a_wdata), .a_rvalid(a_rvalid), .a_rdata(a_rdata), .a_err(a_err),
        .b_valid(b_valid), .b_ready(b_ready), .b_we(b_we), .b_size(b_size), .b_addr(b_addr),
        .b_wdata(b_wdata), .b_rvalid(b_rvalid), .b_rdata(b_rdata), .b_err(b_err),
        .conflict_cnt(conflict_cnt), .mem_readcontrol(mem_readcontrol),
        .mem_writecontrol(mem_writecontrol), .mem_address(mem_address),
        .mem_writedata(mem_writedata), .mem_read_data(mem_read_data)
    );

    dmem_arbiter #(.DEPTH_WORDS(256), .FIXED_PRIO(1'b1)) dut_fixed (
        .clk(clk), .rst_n(rst_n),
        .a_valid(a_valid), .a_ready(f_a_ready), .a_we(a_we), .a_size(a_size), .a_addr(a_addr),
        .a_wdata(a_wdata), .a_rvalid(f_a_rvalid), .a_rdata(f_a_rdata), .a_err(f_a_err),
        .b_valid(b_valid), .b_ready(f_b_ready), .b_we(b_we), .b_size(b_size), .b_addr(b_addr),
        .b_wdata(b_wdata), .b_rvalid(f_b_rvalid), .b_rdata(f_b_rdata), .b_err(f_b_err),
        .conflict_cnt(f_conflict_cnt), .mem_readcontrol(f_mem_readcontrol),
        .mem_writecontrol(f_mem_writecontrol), .mem_address(f_mem_address),
        .mem_writedata(f_mem_writedata), .mem_read_data(32'h0)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- memory device on the arbiter's memory port ----------------
    logic [7:0] emem [0:1023];
    bit         emem_init = 1'b0;

    function automatic logic [31:0] env_read(input logic [2:0] rc, input logic [31:0] ad);
        logic [9:0]  base;
        logic [31:0] w;
        base = {ad[9:2], 2'b00};
        w = {emem[base + 10'd3], emem[base + 10'd2], emem[base + 10'd1], emem[base]};
        w = w >> (8 * ad[1:0]);
        case (rc)
            3'b000:  return {{24{w[7]}}, w[7:0]};
            3'b001:  return {{16{w[15]}}, w[15:0]};
            3'b010:  return w;
            3'b100:  return {24'h0, w[7:0]};
            3'b101:  return {16'h0, w[15:0]};
            default: return 32'h0;
        endcase
    endfunction

    assign mem_read_data = env_read(mem_readcontrol, mem_address);

    always @(posedge clk) begin
        if (!emem_init) begin
            for (int i = 0; i < 256; i++) begin
                emem[4*i]     <= 8'(i);
                emem[4*i + 1] <= 8'h00;
                emem[4*i + 2] <= 8'hDE;
                emem[4*i + 3] <= 8'hC0;
            end
            emem_init <= 1'b1;
        end else if (mem_writecontrol != 3'b111) begin
            emem[mem_address[9:0]] <= mem_writedata[7:0];
            if (mem_writecontrol == 3'b001 || mem_writecontrol == 3'b010)
                emem[mem_address[9:0] + 10'd1] <= mem_writedata[15:8];
            if (mem_writecontrol == 3'b010) begin
                emem[mem_address[9:0] + 10'd2] <= mem_writedata[23:16];
                emem[mem_address[9:0] + 10'd3] <= mem_writedata[31:24];
            end
        end
    end

    // ---------------- reference model: words, lane masks, expected responses ----------------
    logic [31:0] mword [0:255];
    bit          m_init = 1'b0;
    bit          m_last_b;
    logic        ea_rv, eb_rv, ea_er, eb_er;
    logic [31:0] ea_rd, eb_rd;
    logic [15:0] e_cnt;

    function automatic bit model_err(input bit we, input logic [2:0] size, input logic [31:0] addr);
        bit e = 0;
        if (addr >= 32'd1024) e = 1;
        if ((size == 3'd1 || size == 3'd5) && addr[0]) e = 1;
        if (size == 3'd2 && addr[1:0] != 2'b00) e = 1;
        if (size == 3'd3 || size == 3'd6 || size == 3'd7) e = 1;
        if (we && size >= 3'd4) e = 1;
        return e;
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] size, input logic [31:0] addr);
        logic [31:0] v;
        v = mword[addr[9:2]] >> (8 * addr[1:0]);
        if (size == 3'd0) return {{24{v[7]}}, v[7:0]};
        if (size == 3'd1) return {{16{v[15]}}, v[15:0]};
        if (size == 3'd4) return v & 32'hFF;
        if (size == 3'd5) return v & 32'hFFFF;
        return v;
    endfunction

    task automatic model_store(input logic [2:0] size, input logic [31:0] addr, input logic [31:0] d);
        logic [31:0] mask;
        mask = (size == 3'd0) ? 32'hFF : (size == 3'd1) ? 32'hFFFF : 32'hFFFF_FFFF;
        mask = mask << (8 * addr[1:0]);
        mword[addr[9:2]] = (mword[addr[9:2]] & ~mask) | ((d << (8 * addr[1:0])) & mask);
    endtask

    always @(negedge clk) begin
        bit ga, gb, we, er;
        logic [2:0]  sz;
        logic [31:0] ad, wd;
        if (!m_init) begin
            for (int i = 0; i < 256; i++) mword[i] = 32'hC0DE0000 + 32'(i);
            m_init = 1'b1;
        end
        if (!rst_n) begin
            m_last_b = 1'b1;
            {ea_rv, eb_rv, ea_er, eb_er} = 4'b0;
            ea_rd = 32'h0;
            eb_rd = 32'h0;
            e_cnt = 16'h0;
        end
        chk("a_rvalid", a_rvalid, ea_rv);
        chk("b_rvalid", b_rvalid, eb_rv);
        chk("a_err", a_err, ea_er);
        chk("b_err", b_err, eb_er);
        chk("a_rdata", a_rdata, ea_rd);
        chk("b_rdata", b_rdata, eb_rd);
        chk("conflict_cnt", conflict_cnt, e_cnt);
        chk("f_conflict_cnt", f_conflict_cnt, e_cnt);
        if (!rst_n) begin
            chk("rst_readcontrol", mem_readcontrol, 3'b111);
            chk("rst_writecontrol", mem_writecontrol, 3'b111);
        end else begin
            ga = a_valid && (!b_valid || m_last_b);
            gb = b_valid && !ga;
            chk("a_ready", a_ready, ga);
            chk("b_ready", b_ready, gb);
            chk("f_a_ready", f_a_ready, a_valid);
            chk("f_b_ready", f_b_ready, b_valid && !a_valid);
            we = gb ? b_we : a_we;
            sz = gb ? b_size : a_size;
            ad = gb ? b_addr : a_addr;
            wd = gb ? b_wdata : a_wdata;
            er = model_err(we, sz, ad);
            chk("readcontrol", mem_readcontrol, ((ga || gb) && !er && !we) ? sz : 3'b111);
            chk("writecontrol", mem_writecontrol, ((ga || gb) && !er && we) ? sz : 3'b111);
            chk("mem_address", mem_address, (ga || gb) ? ad : 32'h0);
            chk("mem_writedata", mem_writedata, (ga || gb) ? wd : 32'h0);
            ea_rv = ga;
            eb_rv = gb;
            if (ga) begin
                ea_er = er;
                ea_rd = (!we && !er) ? model_load(sz, ad) : 32'h0;
            end
            if (gb) begin
                eb_er = er;
                eb_rd = (!we && !er) ? model_load(sz, ad) : 32'h0;
            end
            if ((ga || gb) && we && !er) model_store(sz, ad, wd);
            if (ga || gb) m_last_b = gb;
            if (a_valid && b_valid && e_cnt != 16'hFFFF) e_cnt = e_cnt + 16'd1;
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_a(input logic we, input logic [2:0] sz, input logic [31:0] ad, input logic [31:0] wd);
        a_valid = 1'b1; a_we = we; a_size = sz; a_addr = ad; a_wdata = wd;
    endtask

    task automatic set_b(input logic we, input logic [2:0] sz, input logic [31:0] ad, input logic [31:0] wd);
        b_valid = 1'b1; b_we = we; b_size = sz; b_addr = ad; b_wdata = wd;
    endtask

    task automatic idle();
        a_valid = 1'b0; a_we = 1'b0; a_size = 3'b010; a_addr = 32'h0; a_wdata = 32'h0;
        b_valid = 1'b0; b_we = 1'b0; b_size = 3'b010; b_addr = 32'h0; b_wdata = 32'h0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] a_order;
        a_order = 4'b0101;
        rst_n = 1'b0;
        idle();
        repeat (3) step();
        chk("reset_conflict", conflict_cnt, 16'h0);
        chk("reset_a_rvalid", a_rvalid, 1'b0);
        rst_n = 1'b1;
        step();

        // Round-robin tie: A,B,A,B; fixed-priority copy grants A throughout
        set_a(1'b0, 3'b010, 32'h20, 32'h0);
        set_b(1'b0, 3'b010, 32'h24, 32'h0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); #1;
            chk("tie_a_ready", a_ready, a_order[i]);
            chk("tie_b_ready", b_ready, !a_order[i]);
            chk("tie_fixed_a_ready", f_a_ready, 1'b1);
            chk("tie_fixed_b_ready", f_b_ready, 1'b0);
            step();
        end
        idle();
        chk("tie_conflict_cnt", conflict_cnt, 16'd4);
        chk("tie_b_rdata", b_rdata, 32'hC0DE0009);

        // A lw 0x10
        set_a(1'b0, 3'b010, 32'h10, 32'h0);
        @(negedge clk); #1;
        chk("lw_a_ready", a_ready, 1'b1);
        chk("lw_readcontrol", mem_readcontrol, 3'b010);
        step();
        idle();
        chk("lw_a_rvalid", a_rvalid, 1'b1);
        chk("lw_a_rdata", a_rdata, 32'hC0DE0004);

        // Store byte then load it back on the next cycle
        set_a(1'b1, 3'b000, 32'h13, 32'hAB);
        step();
        set_a(1'b0, 3'b100, 32'h13, 32'h0);
        step();
        idle();
        chk("sb_lbu_rdata", a_rdata, 32'h000000AB);
        set_a(1'b1, 3'b000, 32'h13, 32'h80);
        step();
        set_a(1'b0, 3'b000, 32'h13, 32'h0);
        step();
        set_a(1'b0, 3'b010, 32'h10, 32'h0);
        chk("sb_lb_rdata", a_rdata, 32'hFFFFFF80);
        step();
        idle();
        chk("sb_word_rdata", a_rdata, 32'h80DE0004);

        // Rejected requests
        set_b(1'b0, 3'b010, 32'h6, 32'h0);
        @(negedge clk); #1;
        chk("lw_mis_readcontrol", mem_readcontrol, 3'b111);
        chk("lw_mis_writecontrol", mem_writecontrol, 3'b111);
        step();
        chk("lw_mis_b_rvalid", b_rvalid, 1'b1);
        chk("lw_mis_b_err", b_err, 1'b1);
        chk("lw_mis_b_rdata", b_rdata, 32'h0);
        set_b(1'b1, 3'b001, 32'h401, 32'h1234);
        step();
        chk("sh_range_b_err", b_err, 1'b1);
        set_b(1'b1, 3'b100, 32'h8, 32'h55);
        @(negedge clk); #1;
        chk("sbu_writecontrol", mem_writecontrol, 3'b111);
        step();
        chk("sbu_b_err", b_err, 1'b1);
        set_b(1'b0, 3'b011, 32'h8, 32'h0);
        step();
        chk("size011_b_err", b_err, 1'b1);
        set_b(1'b0, 3'b010, 32'h3FC, 32'h0);
        step();
        chk("lw_top_b_err", b_err, 1'b0);
        chk("lw_top_b_rdata", b_rdata, 32'hC0DE00FF);
        set_b(1'b0, 3'b010, 32'h8, 32'h0);
        step();
        idle();
        chk("lw_word2_b_rdata", b_rdata, 32'hC0DE0002);

        // Reset lands before the edge that would complete an A request
        step();
        set_a(1'b0, 3'b010, 32'h10, 32'h0);
        @(negedge clk); #1;
        rst_n = 1'b0;
        step();
        chk("rst_drop_a_rvalid", a_rvalid, 1'b0);
        @(negedge clk); #1;
        chk("rst_held_readcontrol", mem_readcontrol, 3'b111);
        step();
        chk("rst_drop_a_rvalid2", a_rvalid, 1'b0);
        rst_n = 1'b1;
        set_b(1'b0, 3'b010, 32'h4, 32'h0);
        @(negedge clk); #1;
        chk("post_rst_tie_a_ready", a_ready, 1'b1);
        chk("post_rst_tie_b_ready", b_ready, 1'b0);
        step();

        // Sustained conflicts saturate the counter
        set_a(1'b0, 3'b010, 32'h0, 32'h0);
        set_b(1'b0, 3'b010, 32'h4, 32'h0);
        repeat (65600) step();
        idle();
        chk("sat_conflict_cnt", conflict_cnt, 16'hFFFF);
        chk("sat_f_conflict_cnt", f_conflict_cnt, 16'hFFFF);
        step();
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
